fetch_pipe_ctrl: RTL

Front-end pipeline executor for the 8-bit pipelined core. It consumes the hazard unit's stall, flush and bubble commands and applies them cycle by cycle.
- Owns the PC register, the instruction-memory address, the IF/ID pipeline register and the ID/EX bubble flag.
- Performs the reset-vector boot fetch.
- Checks the hazard protocol for illegal stall lengths.

---
 rtl/core_pkg.sv | 25 ++
 rtl/fetch_stall_monitor.sv | 79 +++++++
 rtl/fetch_pipe_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// ============================================================================
// Module      : core_pkg
// Description : Shared widths, NOP encoding, front-end FSM states and opcodes
//               for the 8-bit pipelined core.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package core_pkg;

    localparam int         DATA_W      = 8;
    localparam logic [7:0] NOP_INSTR   = 8'h00;

    // Opcodes the hazard unit decodes as loads (load-use detection)
    localparam logic [3:0] OP_LOAD     = 4'd7;
    localparam logic [3:0] OP_LOAD_IDX = 4'd12;

    typedef enum logic [0:0] {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/fetch_stall_monitor.sv
// ============================================================================
// Module      : fetch_stall_monitor
// Description : Tracks consecutive stall cycles and flags hazard-protocol
//               violations. Optional FETCH_PERF_CNT_EN adds perf counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_stall_monitor #(
    parameter int MAX_STALL = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        pc_en,
    input  logic        if_id_en,
    input  logic        flush,
    input  logic        bt,
    output logic        stall_err
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0] perf_stall_cnt,
    output logic [15:0] perf_flush_cnt
`endif
);

    localparam int                 c_cnt_w = $clog2(MAX_STALL + 2);
    localparam logic [c_cnt_w-1:0] c_limit = c_cnt_w'(MAX_STALL);
    localparam logic [c_cnt_w-1:0] c_sat   = c_cnt_w'(MAX_STALL + 1);

    logic [c_cnt_w-1:0] r_stall_cnt;
    logic               r_stall_err;
    logic               w_stall;
    logic               w_overrun;
    logic               w_mismatch;

    assign w_stall    = run & ~pc_en & ~if_id_en & ~bt;
    assign w_overrun  = w_stall & (r_stall_cnt == c_limit);
    // PC and IF/ID must move together unless a redirect is killing IF/ID
    assign w_mismatch = run & ~bt & ~flush & (pc_en ^ if_id_en);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_stall_err <= 1'b0;
        end else begin
            if (!w_stall)
                r_stall_cnt <= '0;
            else if (r_stall_cnt != c_sat)
                r_stall_cnt <= r_stall_cnt + c_cnt_w'(1);
            r_stall_err <= r_stall_err | w_overrun | w_mismatch;
        end
    end

    assign stall_err = r_stall_err;

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] r_perf_stall;
    logic [15:0] r_perf_flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_stall <= '0;
            r_perf_flush <= '0;
        end else begin
            if (w_stall && (r_perf_stall != 16'hFFFF))
                r_perf_stall <= r_perf_stall + 16'd1;
            if (run && (flush || bt) && (r_perf_flush != 16'hFFFF))
                r_perf_flush <= r_perf_flush + 16'd1;
        end
    end

    assign perf_stall_cnt = r_perf_stall;
    assign perf_flush_cnt = r_perf_flush;
`endif

endmodule

`default_nettype wire

// File: rtl/fetch_pipe_ctrl.sv
// ============================================================================
// Module      : fetch_pipe_ctrl
// Description : Front-end executor: PC, imem address, IF/ID register and ID/EX
//               bubble. Optional FETCH_PERF_CNT_EN exposes perf counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_pipe_ctrl #(
    parameter int                DATA_W         = core_pkg::DATA_W,
    parameter logic [DATA_W-1:0] NOP_INSTR      = core_pkg::NOP_INSTR,
    parameter logic [DATA_W-1:0] RESET_VEC_ADDR = '0,
    parameter int                MAX_STALL      = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pc_en,
    input  logic              if_id_en,
    input  logic              flush,
    input  logic              control_zero,
    input  logic              bt,
    input  logic [DATA_W-1:0] branch_target,
    input  logic [DATA_W-1:0] imem_data,
    output logic [DATA_W-1:0] imem_addr,
    output logic [DATA_W-1:0] if_id_instr,
    output logic [DATA_W-1:0] if_id_pc_plus1,
    output logic              if_id_valid,
    output logic              id_ex_bubble,
    output logic              stall_err
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0]       perf_stall_cnt,
    output logic [15:0]       perf_flush_cnt
`endif
);

    import core_pkg::*;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DATA_W-1:0] r_pc;
    logic [DATA_W-1:0] r_instr;
    logic [DATA_W-1:0] r_pc_plus1;
    logic              r_valid;
    logic              r_bubble;

    logic [DATA_W-1:0] w_pc_nxt;
    logic [DATA_W-1:0] w_instr_nxt;
    logic [DATA_W-1:0] w_pc_plus1_nxt;
    logic              w_valid_nxt;
    logic              w_bubble_nxt;
    logic [DATA_W-1:0] w_pc_inc;
    logic              w_run;

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= BOOT;
        else
            r_state <= w_state_nxt;
    end

    assign w_run    = (r_state == RUN);
    assign w_pc_inc = r_pc + DATA_W'(1);

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_instr_nxt    = r_instr;
        w_pc_plus1_nxt = r_pc_plus1;
        w_valid_nxt    = r_valid;
        w_bubble_nxt   = r_bubble;
        imem_addr      = r_pc;
        case (r_state)
            BOOT: begin
                // Boot fetch reads the initial PC from the reset vector slot
                imem_addr    = RESET_VEC_ADDR;
                w_pc_nxt     = imem_data;
                w_instr_nxt  = NOP_INSTR;
                w_valid_nxt  = 1'b0;
                w_bubble_nxt = 1'b1;
                w_state_nxt  = RUN;
            end
            RUN: begin
                if (bt)
                    w_pc_nxt = branch_target;
                else if (pc_en)
                    w_pc_nxt = w_pc_inc;

                if (bt || flush) begin
                    w_instr_nxt = NOP_INSTR;
                    w_valid_nxt = 1'b0;
                end else if (if_id_en) begin
                    w_instr_nxt    = imem_data;
                    w_pc_plus1_nxt = w_pc_inc;
                    w_valid_nxt    = 1'b1;
                end

                // Registered so it lines up with the slot ID/EX consumes next
                w_bubble_nxt = control_zero | bt | ~r_valid;
            end
            default: w_state_nxt = BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= '0;
            r_instr    <= NOP_INSTR;
            r_pc_plus1 <= '0;
            r_valid    <= 1'b0;
            r_bubble   <= 1'b1;
        end else begin
            r_pc       <= w_pc_nxt;
            r_instr    <= w_instr_nxt;
            r_pc_plus1 <= w_pc_plus1_nxt;
            r_valid    <= w_valid_nxt;
            r_bubble   <= w_bubble_nxt;
        end
    end

    assign if_id_instr    = r_instr;
    assign if_id_pc_plus1 = r_pc_plus1;
    assign if_id_valid    = r_valid;
    assign id_ex_bubble   = r_bubble;

    fetch_stall_monitor #(
        .MAX_STALL (MAX_STALL)
    ) u_stall_monitor (
        .clk            (clk),
        .rst            (rst),
        .run            (w_run),
        .pc_en          (pc_en),
        .if_id_en       (if_id_en),
        .flush          (flush),
        .bt             (bt),
        .stall_err      (stall_err)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

endmodule

`default_nettype wire
